// File: rtl/ysyx_25040111_cti_dec.sv
// rtl/ysyx_25040111_cti_dec.sv - control-transfer decode stage with main/skid entry buffering
// Raw inst/pc are buffered; decode runs off the main entry so outputs stay stable under stall.
module ysyx_25040111_cti_dec #(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_kind,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_link,
  output logic            out_misalign,
  output logic            out_illegal
);

  localparam logic [1:0] KIND_NONE   = 2'd0;
  localparam logic [1:0] KIND_JAL    = 2'd1;
  localparam logic [1:0] KIND_JALR   = 2'd2;
  localparam logic [1:0] KIND_BRANCH = 2'd3;

  logic            main_valid, skid_valid;
  logic [31:0]     main_inst, skid_inst;
  logic [XLEN-1:0] main_pc, skid_pc;
  logic            accept, main_free;

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready && !flush;
  assign main_free = !main_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      // skid_valid blocks accept, so the two sources never compete for main
      main_valid <= skid_valid || accept;
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && main_free) begin
      if (skid_valid) begin
        main_inst <= skid_inst;
        main_pc   <= skid_pc;
      end else if (accept) begin
        main_inst <= in_inst;
        main_pc   <= in_pc;
      end
    end
    if (!flush && !main_free && accept) begin
      skid_inst <= in_inst;
      skid_pc   <= in_pc;
    end
  end

  logic [6:0] opcode;
  assign opcode     = main_inst[6:0];
  assign out_funct3 = main_inst[14:12];
  assign out_rd     = main_inst[11:7];
  assign out_rs1    = main_inst[19:15];
  assign out_rs2    = main_inst[24:20];
  assign out_pc     = main_pc;
  assign out_valid  = main_valid;

  always_comb begin
    case (opcode)
      7'b1101111: out_kind = KIND_JAL;
      7'b1100111: out_kind = KIND_JALR;
      7'b1100011: out_kind = KIND_BRANCH;
      default:    out_kind = KIND_NONE;
    endcase
  end

  always_comb begin
    out_imm = '0;
    case (out_kind)
      KIND_JAL:    out_imm = {{(XLEN-21){main_inst[31]}}, main_inst[31], main_inst[19:12],
                              main_inst[20], main_inst[30:21], 1'b0};
      KIND_JALR:   out_imm = {{(XLEN-12){main_inst[31]}}, main_inst[31:20]};
      KIND_BRANCH: out_imm = {{(XLEN-13){main_inst[31]}}, main_inst[31], main_inst[7],
                              main_inst[30:25], main_inst[11:8], 1'b0};
      default:     out_imm = '0;
    endcase
  end

  logic pc_rel;
  assign pc_rel     = (out_kind == KIND_JAL) || (out_kind == KIND_BRANCH);
  assign out_target = pc_rel ? (main_pc + out_imm) : '0;

  // With compressed instructions present every even address is a legal target
  assign out_misalign = (IALIGN == 32) ? (pc_rel && out_target[1]) : 1'b0;

  assign out_link = ((out_kind == KIND_JAL) || (out_kind == KIND_JALR)) && (out_rd != 5'd0);

  always_comb begin
    out_illegal = 1'b0;
    if (out_kind == KIND_JALR)
      out_illegal = (out_funct3 != 3'b000);
    else if (out_kind == KIND_BRANCH)
      out_illegal = (out_funct3 == 3'b010) || (out_funct3 == 3'b011);
  end

endmodule

// File: tb/tb_ysyx_25040111_cti_dec.sv
// tb/tb_ysyx_25040111_cti_dec.sv - directed self-checking bench for ysyx_25040111_cti_dec
// Three instances cover the default, IALIGN=16 and XLEN=64 configurations.
module tb_ysyx_25040111_cti_dec;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic [63:0] in_pc64;

  logic        a_in_ready, a_out_valid, a_link, a_mis, a_ill;
  logic [1:0]  a_kind;
  logic [2:0]  a_f3;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [31:0] a_imm, a_tgt, a_pc;

  logic        b_in_ready, b_out_valid, b_link, b_mis, b_ill;
  logic [1:0]  b_kind;
  logic [2:0]  b_f3;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [31:0] b_imm, b_tgt, b_pc;

  logic        c_in_ready, c_out_valid, c_link, c_mis, c_ill;
  logic [1:0]  c_kind;
  logic [2:0]  c_f3;
  logic [4:0]  c_rd, c_rs1, c_rs2;
  logic [63:0] c_imm, c_tgt, c_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_25040111_cti_dec #(.XLEN(32), .IALIGN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_kind(a_kind), .out_funct3(a_f3), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_imm(a_imm), .out_target(a_tgt), .out_pc(a_pc), .out_link(a_link),
    .out_misalign(a_mis), .out_illegal(a_ill));

  ysyx_25040111_cti_dec #(.XLEN(32), .IALIGN(16)) dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_kind(b_kind), .out_funct3(b_f3), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_imm(b_imm), .out_target(b_tgt), .out_pc(b_pc), .out_link(b_link),
    .out_misalign(b_mis), .out_illegal(b_ill));

  ysyx_25040111_cti_dec #(.XLEN(64), .IALIGN(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_inst(in_inst), .in_pc(in_pc64), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_kind(c_kind), .out_funct3(c_f3), .out_rd(c_rd), .out_rs1(c_rs1), .out_rs2(c_rs2),
    .out_imm(c_imm), .out_target(c_tgt), .out_pc(c_pc), .out_link(c_link),
    .out_misalign(c_mis), .out_illegal(c_ill));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one entry to all instances, clock it into main, release the input
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [63:0] pc64);
    in_inst  = inst;
    in_pc    = pc;
    in_pc64  = pc64;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_pc = '0; in_pc64 = '0;
    #12;
    chk("reset_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, a_in_ready}, 64'd1);
    tick();
    rst = 1'b0;

    issue(32'h008000EF, 32'h80000000, 64'hFFFFFFFFFFFFFFFC);
    chk("jal_valid", {63'd0, a_out_valid}, 64'd1);
    chk("jal_kind", {62'd0, a_kind}, 64'd1);
    chk("jal_rd", {59'd0, a_rd}, 64'd1);
    chk("jal_imm", {32'd0, a_imm}, 64'd8);
    chk("jal_target", {32'd0, a_tgt}, 64'h80000008);
    chk("jal_link", {63'd0, a_link}, 64'd1);
    chk("x64_jal_target_wrap", c_tgt, 64'h4);
    chk("x64_jal_imm", c_imm, 64'd8);

    issue(32'hFFDFF06F, 32'h80000010, 64'h0);
    chk("jal_neg_imm", {32'd0, a_imm}, 64'hFFFFFFFC);
    chk("jal_neg_target", {32'd0, a_tgt}, 64'h8000000C);
    chk("jal_neg_link", {63'd0, a_link}, 64'd0);
    chk("x64_neg_imm", c_imm, 64'hFFFFFFFFFFFFFFFC);

    issue(32'h00208863, 32'h00000100, 64'h0);
    chk("br_kind", {62'd0, a_kind}, 64'd3);
    chk("br_rs1", {59'd0, a_rs1}, 64'd1);
    chk("br_rs2", {59'd0, a_rs2}, 64'd2);
    chk("br_funct3", {61'd0, a_f3}, 64'd0);
    chk("br_imm", {32'd0, a_imm}, 64'd16);
    chk("br_target", {32'd0, a_tgt}, 64'h110);
    chk("br_illegal", {63'd0, a_ill}, 64'd0);

    issue(32'h0020006F, 32'h00000000, 64'h0);
    chk("mis_ialign32", {63'd0, a_mis}, 64'd1);
    chk("mis_ialign16", {63'd0, b_mis}, 64'd0);
    chk("mis_target", {32'd0, a_tgt}, 64'd2);

    issue(32'h00001067, 32'h00000040, 64'h0);
    chk("jalr_kind", {62'd0, a_kind}, 64'd2);
    chk("jalr_illegal", {63'd0, a_ill}, 64'd1);
    chk("jalr_target", {32'd0, a_tgt}, 64'd0);
    chk("jalr_link", {63'd0, a_link}, 64'd0);

    issue(32'h0020A863, 32'h00000100, 64'h0);
    chk("br_f3_010_illegal", {63'd0, a_ill}, 64'd1);

    issue(32'h00000013, 32'h00000200, 64'h0);
    chk("none_kind", {62'd0, a_kind}, 64'd0);
    chk("none_imm", {32'd0, a_imm}, 64'd0);
    chk("none_target", {32'd0, a_tgt}, 64'd0);
    tick();
    chk("drain_empty", {63'd0, a_out_valid}, 64'd0);

    // Backpressure: A, B, C with downstream stalled
    out_ready = 1'b0;
    in_inst = 32'h008000EF; in_valid = 1'b1;
    in_pc = 32'h10; tick();
    in_pc = 32'h20; tick();
    in_pc = 32'h30;
    chk("bp_hold_a", {32'd0, a_pc}, 64'h10);
    chk("bp_in_ready_low", {63'd0, a_in_ready}, 64'd0);
    tick();
    chk("bp_still_a", {32'd0, a_pc}, 64'h10);
    chk("bp_still_valid", {63'd0, a_out_valid}, 64'd1);
    chk("bp_target_stable", {32'd0, a_tgt}, 64'h18);
    out_ready = 1'b1;
    tick();
    chk("bp_deliver_b", {32'd0, a_pc}, 64'h20);
    chk("bp_in_ready_back", {63'd0, a_in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_deliver_c", {32'd0, a_pc}, 64'h30);
    chk("bp_c_valid", {63'd0, a_out_valid}, 64'd1);
    tick();
    chk("bp_empty_after", {63'd0, a_out_valid}, 64'd0);

    // Flush with both entries full and a live input
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h50; tick();
    in_pc = 32'h60; tick();
    in_pc = 32'h70; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, a_in_ready}, 64'd1);
    tick();
    chk("flush_input_dropped", {63'd0, a_out_valid}, 64'd0);

    // Asynchronous reset with both entries full, then normal accept
    in_valid = 1'b1;
    in_pc = 32'h80; tick();
    in_pc = 32'h90; tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("async_rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    issue(32'h008000EF, 32'h000000A0, 64'h0);
    chk("post_rst_valid", {63'd0, a_out_valid}, 64'd1);
    chk("post_rst_pc", {32'd0, a_pc}, 64'hA0);
    tick();
    chk("post_rst_no_dup", {63'd0, a_out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25040111_cti_dec.md
YSYX_25040111_CTI_DEC -- requirements
Module: ysyx_25040111_cti_dec

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter IALIGN, default 32, meaning instruction alignment in bits; legal values are 32 and 16.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  discards all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream entry valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept an entry.
REQ-008 SHALL have port in_inst  input  32  raw instruction.
REQ-009 SHALL have port in_pc  input  XLEN  instruction PC.
REQ-010 SHALL have port out_valid  output  1  decoded entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the entry.
REQ-012 SHALL have port out_kind  output  2  entry class: 0 NONE, 1 JAL, 2 JALR, 3 BRANCH.
REQ-013 SHALL have port out_funct3  output  3  inst[14:12].
REQ-014 SHALL have ports out_rd, out_rs1, out_rs2  output  5 each  inst[11:7], inst[19:15], inst[24:20].
REQ-015 SHALL have port out_imm  output  XLEN  sign-extended control-transfer immediate.
REQ-016 SHALL have port out_target  output  XLEN  pc+imm for JAL and BRANCH; 0 for JALR and NONE.
REQ-017 SHALL have port out_pc  output  XLEN  PC of the entry.
REQ-018 SHALL have port out_link  output  1  JAL/JALR with rd!=0.
REQ-019 SHALL have port out_misalign  output  1  static target misaligned.
REQ-020 SHALL have port out_illegal  output  1  bad funct3 on a CTI opcode.

Function
REQ-021 Decode SHALL classify opcode 1101111 as JAL, 1100111 as JALR, 1100011 as BRANCH, all others NONE.
REQ-022 JAL imm SHALL be {inst[31],inst[19:12],inst[20],inst[30:21],0}, sign-extended to XLEN.
REQ-023 JALR imm SHALL be inst[31:20], sign-extended; BRANCH imm SHALL be {inst[31],inst[7],inst[30:25],inst[11:8],0}, sign-extended; NONE imm SHALL be 0.
REQ-024 out_target SHALL be computed modulo 2^XLEN, with wrap-around and no overflow flag.
REQ-025 With IALIGN=32, out_misalign SHALL be target[1] for JAL/BRANCH, else 0; with IALIGN=16, out_misalign SHALL be 0.
REQ-026 out_illegal SHALL be 1 for JALR with funct3!=000 and for BRANCH with funct3 010 or 011, else 0.
REQ-027 An entry is accepted when in_valid & in_ready & !flush.
REQ-028 The stage SHALL hold two registered entries: main, which drives out_*, and skid; latency from accept to out_valid SHALL be 1 cycle.
REQ-029 in_ready SHALL equal !skid_valid, as a registered signal that does not depend combinationally on out_ready.
REQ-030 If main is empty or out_ready=1, main SHALL load skid when skid_valid=1; otherwise it SHALL load the accepted entry; otherwise it SHALL go empty.
REQ-031 If main is valid and out_ready=0, an accepted entry SHALL go to skid.
REQ-032 Simultaneous out_ready=1 and skid_valid=1: skid SHALL move to main and skid SHALL become empty in the same edge.
REQ-033 While out_valid=1 and out_ready=0, all out_* SHALL remain stable.
REQ-034 Order SHALL be preserved; entries SHALL be neither dropped nor duplicated except by flush.
REQ-035 flush=1 SHALL clear main_valid and skid_valid at the next edge and drop any same-cycle input; flush takes priority over accept and transfer.
REQ-036 Data fields SHALL not be reset and SHALL be ignored when the matching valid is 0.

Reset
REQ-037 While rst=1, out_valid=0, skid_valid=0 and in_ready=1, asynchronously.
REQ-038 Reset mid-transfer SHALL discard both entries; the first rising edge after deassertion SHALL accept normally.

Verification
REQ-039 XLEN=32: in_inst=0x008000EF, in_pc=0x80000000 -> next cycle kind=1, rd=1, imm=8, target=0x80000008, link=1.
REQ-040 in_inst=0xFFDFF06F, pc=0x80000010 -> imm=0xFFFFFFFC, target=0x8000000C, link=0.
REQ-041 in_inst=0x00208863, pc=0x100 -> kind=3, rs1=1, rs2=2, funct3=0, imm=16, target=0x110.
REQ-042 in_inst=0x0020006F, pc=0 -> with IALIGN=32, misalign=1; with IALIGN=16, misalign=0. in_inst=0x00001067 -> kind=2, illegal=1.
REQ-043 Backpressure case: stream A,B,C with out_ready=0 -> A is held on the outputs, B goes to skid, and in_ready=0 so C is stalled. Then raise out_ready -> A, B, C are delivered in order with no loss.
REQ-044 Flush case: flush with both entries full plus in_valid=1 -> out_valid=0 and in_ready=1 next cycle, and the input is dropped. XLEN=64: pc=0xFFFFFFFFFFFFFFFC with JAL +8 -> target=0x4.
